// File: rtl/stark_sau_wb_queue.sv
// stark_sau_wb_queue
//   Result-holding queue behind the SAU output stage. Captures one SAU result
//   per cycle and presents the oldest surviving one to the shared register-file
//   writeback port through a valid/ack handshake. Results whose ROB entry is
//   stomped are dropped: on entry, or lazily once they reach the head.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   v_i .. pRd_i    SAU result packet (valid, value, byte WEs + tag WE,
//                   exception bytes, checkpoint, ROB index, physical target)
//   stomp           ROB stomp bitmask, bit n kills ROB entry n
//   wb_ack          writeback port took the presented entry
//   wb_v .. wb_pRd  head entry presented to the writeback port
//   issue_stall     registered issue hold towards the SAU
//   count           occupied slots, dead-but-unreclaimed slots included
//   ovf             sticky overflow (result dropped while full)
module stark_sau_wb_queue #(
  parameter int WID   = 64,
  parameter int DEP   = 4,
  parameter int NROB  = 16,
  parameter int RNDXW = 4,
  parameter int CPW   = 4,
  parameter int PRW   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   v_i,
  input  logic [WID-1:0]         o_i,
  input  logic [WID/8:0]         we_i,
  input  logic [WID-1:0]         exc_i,
  input  logic [CPW-1:0]         cp_i,
  input  logic [RNDXW-1:0]       rndx_i,
  input  logic [PRW-1:0]         pRd_i,
  input  logic [NROB-1:0]        stomp,
  input  logic                   wb_ack,
  output logic                   wb_v,
  output logic [WID-1:0]         wb_res,
  output logic [WID/8:0]         wb_we,
  output logic [WID-1:0]         wb_exc,
  output logic [CPW-1:0]         wb_cp,
  output logic [RNDXW-1:0]       wb_rndx,
  output logic [PRW-1:0]         wb_pRd,
  output logic                   issue_stall,
  output logic [$clog2(DEP):0]   count,
  output logic                   ovf
);
  localparam int PW = $clog2(DEP);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WID-1:0]   res;
    logic [WID/8:0]   we;
    logic [WID-1:0]   exc;
    logic [CPW-1:0]   cp;
    logic [RNDXW-1:0] rndx;
    logic [PRW-1:0]   prd;
  } ent_t;

  ent_t           slot [DEP];
  logic [DEP-1:0] vld, vld_nxt;
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           full, occ, in_stomp, push, pop, ovf_evt;

  assign full     = (cnt == CW'(DEP));
  assign occ      = (cnt != '0);
  assign in_stomp = stomp[rndx_i];

  // Same-cycle stomp of the head hides it right away; the slot then drains
  // through the dead-reclaim path instead of being written back.
  assign wb_v    = vld[head] & ~stomp[slot[head].rndx];
  assign wb_res  = slot[head].res;
  assign wb_we   = slot[head].we;
  assign wb_exc  = slot[head].exc;
  assign wb_cp   = slot[head].cp;
  assign wb_rndx = slot[head].rndx;
  assign wb_pRd  = slot[head].prd;
  assign count   = cnt;

  // Retire on ack, or reclaim one dead head slot per cycle.
  assign pop     = (wb_v & wb_ack) | (occ & ~wb_v);
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign push    = v_i & ~in_stomp & (~full | pop);
  assign ovf_evt = v_i & ~in_stomp & full & ~pop;
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);

  always_comb begin
    vld_nxt = vld;
    for (int i = 0; i < DEP; i++)
      if (stomp[slot[i].rndx]) vld_nxt[i] = 1'b0;
    if (pop)  vld_nxt[head] = 1'b0;
    // Pushed entry is never stomped, and when full with a pop tail==head,
    // so the set must win over the clears above.
    if (push) vld_nxt[tail] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      vld         <= '0;
      ovf         <= 1'b0;
      issue_stall <= 1'b0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      cnt         <= cnt_nxt;
      vld         <= vld_nxt;
      if (ovf_evt) ovf <= 1'b1;
      // Two-slot margin: one result in the SAU pipe plus one already issued.
      issue_stall <= (cnt_nxt >= CW'(DEP - 2));
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) slot[tail] <= '{res: o_i, we: we_i, exc: exc_i, cp: cp_i,
                              rndx: rndx_i, prd: pRd_i};
  end
endmodule
